// File: rtl/wi23_defs.sv
// Shared opcodes, response codes, FSM state encoding and response builders for dbg_bridge.
// Response builders append the XOR trailer when DBG_BRIDGE_CHECKSUM_EN is defined.
package wi23_defs;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_HOLD  = 8'h48;
  localparam logic [7:0] OP_GO    = 8'h47;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_ADDR_H  = 4'd1;
  localparam state_t ST_ADDR_L  = 4'd2;
  localparam state_t ST_DATA_H  = 4'd3;
  localparam state_t ST_DATA_L  = 4'd4;
  localparam state_t ST_CHK     = 4'd5;
  localparam state_t ST_BUS     = 4'd6;
  localparam state_t ST_RD_WAIT = 4'd7;
  localparam state_t ST_RESP    = 4'd8;

  typedef struct packed {
    logic [1:0] len;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } resp_t;

  function automatic resp_t resp1(input logic [7:0] b);
    resp_t r;
    r.b0 = b;
    r.b2 = 8'h00;
`ifdef DBG_BRIDGE_CHECKSUM_EN
    r.len = 2'd2;
    r.b1  = b;
`else
    r.len = 2'd1;
    r.b1  = 8'h00;
`endif
    return r;
  endfunction

  function automatic resp_t resp2(input logic [7:0] hi, input logic [7:0] lo);
    resp_t r;
    r.b0 = hi;
    r.b1 = lo;
`ifdef DBG_BRIDGE_CHECKSUM_EN
    r.len = 2'd3;
    r.b2  = hi ^ lo;
`else
    r.len = 2'd2;
    r.b2  = 8'h00;
`endif
    return r;
  endfunction

endpackage

// File: rtl/dbg_bridge_if.sv
// UART byte stream and bus-initiator signals of dbg_bridge.
// The slave modport is the bridge's view; master is the surrounding system.
interface dbg_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  rx_valid_i;
  logic [7:0]            rx_data_i;
  logic                  rx_ready_o;
  logic                  tx_valid_o;
  logic [7:0]            tx_data_o;
  logic                  tx_ready_i;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic                  we_o;
  logic                  re_o;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic                  cpu_hold_o;

  modport slave (
    input  rx_valid_i, rx_data_i, tx_ready_i, rdata_i,
    output rx_ready_o, tx_valid_o, tx_data_o, addr_o, wdata_o, we_o, re_o, cpu_hold_o
  );

  modport master (
    output rx_valid_i, rx_data_i, tx_ready_i, rdata_i,
    input  rx_ready_o, tx_valid_o, tx_data_o, addr_o, wdata_o, we_o, re_o, cpu_hold_o
  );
endinterface

// File: rtl/dbg_tx_queue.sv
// Three-entry response byte buffer; presents bytes in order on a valid/ready handshake.
// done pulses on the transfer of the last loaded byte.
module dbg_tx_queue
  import wi23_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  resp_t      resp,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       done
);

  logic [2:0][7:0] byte_q;
  logic [1:0]      len_q;
  logic [1:0]      idx_q;
  logic            valid_q;
  logic            xfer;
  logic            last;

  assign xfer     = valid_q && tx_ready;
  assign last     = (idx_q == len_q - 2'd1);
  assign done     = xfer && last;
  assign tx_valid = valid_q;

  always_comb begin
    case (idx_q)
      2'd0:    tx_data = byte_q[0];
      2'd1:    tx_data = byte_q[1];
      default: tx_data = byte_q[2];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q  <= '0;
      len_q   <= 2'd0;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else if (load) begin
      byte_q  <= {resp.b2, resp.b1, resp.b0};
      len_q   <= resp.len;
      idx_q   <= 2'd0;
      valid_q <= (resp.len != 2'd0);
    end else if (xfer) begin
      if (last) valid_q <= 1'b0;
      else      idx_q   <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/dbg_bridge.sv
// UART-framed debug bridge: decodes write/read/hold/go frames into bus strobes and responses.
// Optional DBG_BRIDGE_CHECKSUM_EN adds a trailing XOR byte to every frame and response.
module dbg_bridge
  import wi23_defs::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic           clk,
  input logic           rst_n,
  dbg_bridge_if.slave   bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state_q, state_d;
  logic [7:0]            op_q, op_d;
  logic [15:0]           addr_sh_q, addr_sh_d;
  logic [15:0]           data_sh_q, data_sh_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
`ifdef DBG_BRIDGE_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  logic       rx_open, rx_acc, go_bus, last_field, q_load, q_done;
  logic [7:0] rx_byte;
  resp_t      q_resp;

  always_comb begin
    case (state_q)
      ST_IDLE, ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L: rx_open = 1'b1;
`ifdef DBG_BRIDGE_CHECKSUM_EN
      ST_CHK:  rx_open = 1'b1;
`endif
      default: rx_open = 1'b0;
    endcase
  end

  // Gated by rst_n so the bridge refuses bytes while held in reset.
  assign bus.rx_ready_o = rst_n && rx_open;
  assign rx_acc         = bus.rx_valid_i && bus.rx_ready_o;
  assign rx_byte        = bus.rx_data_i;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    q_load     = 1'b0;
    q_resp     = '0;
    go_bus     = 1'b0;
    last_field = 1'b0;
`ifdef DBG_BRIDGE_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_acc) begin
          op_d = rx_byte;
`ifdef DBG_BRIDGE_CHECKSUM_EN
          xor_d = rx_byte;
`endif
          case (rx_byte)
            OP_WRITE, OP_READ: state_d = ST_ADDR_H;
            OP_HOLD, OP_GO:    last_field = 1'b1;
            default: begin
              q_load  = 1'b1;
              q_resp  = resp1(NAK);
              state_d = ST_RESP;
            end
          endcase
        end
      end
      ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L, ST_CHK: begin
        if (rx_acc) begin
          cnt_d = '0;
`ifdef DBG_BRIDGE_CHECKSUM_EN
          xor_d = xor_q ^ rx_byte;
`endif
          case (state_q)
            ST_ADDR_H: begin
              addr_sh_d = {addr_sh_q[7:0], rx_byte};
              state_d   = ST_ADDR_L;
            end
            ST_ADDR_L: begin
              addr_sh_d = {addr_sh_q[7:0], rx_byte};
              if (op_q == OP_WRITE) state_d    = ST_DATA_H;
              else                  last_field = 1'b1;
            end
            ST_DATA_H: begin
              data_sh_d = {data_sh_q[7:0], rx_byte};
              state_d   = ST_DATA_L;
            end
            ST_DATA_L: begin
              data_sh_d  = {data_sh_q[7:0], rx_byte};
              last_field = 1'b1;
            end
            default: begin
`ifdef DBG_BRIDGE_CHECKSUM_EN
              if (rx_byte == xor_q) begin
                go_bus = 1'b1;
              end else begin
                q_load  = 1'b1;
                q_resp  = resp1(NAK);
                state_d = ST_RESP;
              end
`else
              state_d = ST_IDLE;
`endif
            end
          endcase
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Abandon a stalled frame silently.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_BUS: begin
        state_d = ST_RESP;
        q_load  = 1'b1;
        q_resp  = resp1(ACK);
        case (op_q)
          OP_READ: begin
            state_d = ST_RD_WAIT;
            q_load  = 1'b0;
          end
          OP_HOLD: hold_d = 1'b1;
          OP_GO:   hold_d = 1'b0;
          default: ;
        endcase
      end
      ST_RD_WAIT: begin
        q_load  = 1'b1;
        q_resp  = resp2(bus.rdata_i[15:8], bus.rdata_i[7:0]);
        state_d = ST_RESP;
      end
      ST_RESP: if (q_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (last_field) begin
`ifdef DBG_BRIDGE_CHECKSUM_EN
      state_d = ST_CHK;
`else
      go_bus = 1'b1;
`endif
    end

    if (go_bus) begin
      state_d = ST_BUS;
      if (op_d == OP_WRITE || op_d == OP_READ) addr_d = ADDR_WIDTH'(addr_sh_d);
      if (op_d == OP_WRITE) wdata_d = DATA_WIDTH'(data_sh_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 8'h00;
      addr_sh_q <= 16'h0000;
      data_sh_q <= 16'h0000;
      addr_q    <= '0;
      wdata_q   <= '0;
      hold_q    <= 1'b0;
      cnt_q     <= '0;
`ifdef DBG_BRIDGE_CHECKSUM_EN
      xor_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
`ifdef DBG_BRIDGE_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  assign bus.we_o       = (state_q == ST_BUS) && (op_q == OP_WRITE);
  assign bus.re_o       = (state_q == ST_BUS) && (op_q == OP_READ);
  assign bus.addr_o     = addr_q;
  assign bus.wdata_o    = wdata_q;
  assign bus.cpu_hold_o = hold_q;

  dbg_tx_queue u_tx_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (q_load),
    .resp     (q_resp),
    .tx_ready (bus.tx_ready_i),
    .tx_valid (bus.tx_valid_o),
    .tx_data  (bus.tx_data_o),
    .done     (q_done)
  );

endmodule

// File: tb/tb_dbg_bridge.sv
// Scoreboard bench for dbg_bridge: frames are modelled at protocol level, expected bus
// events and tx bytes are queued at issue time and popped by an independent monitor.
module tb_dbg_bridge;
  import wi23_defs::*;

  localparam int unsigned TO = 100;
`ifdef DBG_BRIDGE_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  dbg_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bif ();

  dbg_bridge #(
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  typedef struct {
    logic [7:0] b;
    bit         chk_hold;
    logic       hold;
  } tx_exp_t;

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [15:0] data;
  } bus_exp_t;

  tx_exp_t     exp_tx[$];
  bus_exp_t    exp_bus[$];
  logic [15:0] mem [logic [15:0]];
  int          checks = 0;
  int          errors = 0;
  bit          force_low = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response bytes, plus the XOR trailer when checksums are enabled.
  task automatic push_resp(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input bit chk_hold, input logic hold);
    logic [7:0] x;
    exp_tx.push_back('{b0, chk_hold, hold});
    x = b0;
    if (n > 1) begin
      exp_tx.push_back('{b1, chk_hold, hold});
      x = x ^ b1;
    end
    if (CHK_ON) exp_tx.push_back('{x, chk_hold, hold});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bif.rx_valid_i = 1'b1;
    bif.rx_data_i  = b;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = bif.rx_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    check("rx_accept", acc, 1'b1);
    bif.rx_valid_i = 1'b0;
    bif.rx_data_i  = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_tx.size() + exp_bus.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    check("rst_rx_ready", bif.rx_ready_o, 1'b0);
    check("rst_tx_valid", bif.tx_valid_o, 1'b0);
    check("rst_tx_data", bif.tx_data_o, 8'h00);
    check("rst_we", bif.we_o, 1'b0);
    check("rst_re", bif.re_o, 1'b0);
    check("rst_addr", bif.addr_o, 16'h0000);
    check("rst_wdata", bif.wdata_o, 16'h0000);
    check("rst_hold", bif.cpu_hold_o, 1'b0);
  endtask

  // Builds a frame, queues its expected effects, then sends it with random inter-byte gaps.
  task automatic issue_frame(input logic [7:0] op, input logic [15:0] addr,
                             input logic [15:0] data, input bit bad_chk,
                             input int stall_idx, input int stall_cyc);
    logic [7:0] fr[$];
    logic [7:0] x;
    bit         known;
    known = (op == OP_WRITE || op == OP_READ || op == OP_HOLD || op == OP_GO);
    fr.push_back(op);
    if (op == OP_WRITE || op == OP_READ) begin
      fr.push_back(addr[15:8]);
      fr.push_back(addr[7:0]);
    end
    if (op == OP_WRITE) begin
      fr.push_back(data[15:8]);
      fr.push_back(data[7:0]);
    end
    if (CHK_ON && known) begin
      x = 8'h00;
      foreach (fr[i]) x = x ^ fr[i];
      if (bad_chk) x = x ^ 8'h56;
      fr.push_back(x);
    end

    if (!known || (CHK_ON && bad_chk)) begin
      push_resp(1, NAK, 8'h00, 1'b0, 1'b0);
    end else if (op == OP_WRITE) begin
      exp_bus.push_back('{1'b1, addr, data});
      mem[addr] = data;
      push_resp(1, ACK, 8'h00, 1'b0, 1'b0);
    end else if (op == OP_READ) begin
      if (!mem.exists(addr)) mem[addr] = 16'($urandom);
      exp_bus.push_back('{1'b0, addr, 16'h0000});
      push_resp(2, mem[addr][15:8], mem[addr][7:0], 1'b0, 1'b0);
    end else begin
      push_resp(1, ACK, 8'h00, 1'b1, (op == OP_HOLD));
    end

    foreach (fr[i]) begin
      send_byte(fr[i]);
      if (i == stall_idx) repeat (stall_cyc) @(posedge clk);
      else repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic [7:0] op, input logic [15:0] addr,
                       input logic [15:0] data, input bit bad_chk);
    issue_frame(op, addr, data, bad_chk, -1, 0);
    wait_done();
  endtask

  // tx_ready driver
  initial begin
    bif.tx_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bif.tx_ready_i = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on every handshake/strobe and serves read data.
  initial begin
    tx_exp_t  te;
    bus_exp_t be;
    bit       prev_re;
    prev_re     = 1'b0;
    bif.rdata_i = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_re = 1'b0;
      end else begin
        if (bif.tx_valid_o && bif.tx_ready_i) begin
          check("tx_pending", exp_tx.size() != 0, 1'b1);
          if (exp_tx.size() != 0) begin
            te = exp_tx.pop_front();
            check("tx_data", bif.tx_data_o, te.b);
            if (te.chk_hold) check("cpu_hold", bif.cpu_hold_o, te.hold);
          end
        end
        if (bif.we_o || bif.re_o) begin
          check("strobe_excl", bif.we_o & bif.re_o, 1'b0);
          check("bus_pending", exp_bus.size() != 0, 1'b1);
          if (exp_bus.size() != 0) begin
            be = exp_bus.pop_front();
            check("bus_kind", bif.we_o, be.is_wr);
            check("bus_addr", bif.addr_o, be.addr);
            if (be.is_wr) check("bus_wdata", bif.wdata_o, be.data);
          end
        end
        if (bif.re_o) bif.rdata_i = mem.exists(bif.addr_o) ? mem[bif.addr_o] : 16'hDEAD;
        else if (!prev_re) bif.rdata_i = 16'($urandom);
        prev_re = bif.re_o;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         r;
    logic [7:0] b;
    bif.rx_valid_i = 1'b0;
    bif.rx_data_i  = 8'h00;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", bif.rx_ready_o, 1'b1);
    @(posedge clk);
    #1;

    // Directed write and read
    frame(OP_WRITE, 16'hC000, 16'h002A, 1'b0);
    mem[16'h0100] = 16'hBEEF;
    force_low = 1'b1;
    issue_frame(OP_READ, 16'h0100, 16'h0000, 1'b0, -1, 0);
    n = 0;
    while (!bif.tx_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tx_valid_rise", bif.tx_valid_o, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", bif.tx_valid_o, 1'b1);
      check("stall_data", bif.tx_data_o, 8'hBE);
    end
    force_low = 1'b0;
    wait_done();

    // Bad opcode, hold, go
    frame(8'h99, 16'h0000, 16'h0000, 1'b0);
    frame(OP_HOLD, 16'h0000, 16'h0000, 1'b0);
    frame(OP_GO, 16'h0000, 16'h0000, 1'b0);

`ifdef DBG_BRIDGE_CHECKSUM_EN
    frame(OP_READ, 16'h0004, 16'h0000, 1'b0);
    frame(OP_READ, 16'h0004, 16'h0000, 1'b1);
`endif

    // A gap just under the timeout keeps the frame alive
    issue_frame(OP_WRITE, 16'hC002, 16'h1234, 1'b0, 1, TO - 10);
    wait_done();

    // Stalled frame is dropped silently, then a clean read works
    send_byte(OP_WRITE);
    send_byte(8'hC0);
    repeat (TO + 10) @(posedge clk);
    #1;
    check("timeout_idle_ready", bif.rx_ready_o, 1'b1);
    frame(OP_READ, 16'h0002, 16'h0000, 1'b0);

    // Reset between DATA_H and DATA_L
    frame(OP_HOLD, 16'h0000, 16'h0000, 1'b0);
    send_byte(OP_WRITE);
    send_byte(8'hC0);
    send_byte(8'h00);
    send_byte(8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue_frame(8'h2A, 16'h0000, 16'h0000, 1'b0, -1, 0);
    wait_done();
    send_byte(OP_WRITE);
    repeat (TO + 10) @(posedge clk);
    #1;
    wait_done();

    // Randomised frames
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      b = OP_WRITE;
      else if (r <= 6) b = OP_READ;
      else if (r == 7) b = OP_HOLD;
      else if (r == 8) b = OP_GO;
      else begin
        do b = 8'($urandom);
        while (b == OP_WRITE || b == OP_READ || b == OP_HOLD || b == OP_GO);
      end
      frame(b, 16'($urandom_range(0, 7) * 16'h1111), 16'($urandom),
            ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
